// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - 802.11a receive PSDU deframer.
// Drops the SERVICE field, packs PSDU bits LSB-first into bytes and flags the last one.
module rx_deframer #(
  parameter int LEN_W        = 12,
  parameter int SERVICE_BITS = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] Length,
  input  logic             InValid,
  input  logic             Input,
  output logic             OutValid,
  output logic [7:0]       OutByte,
  output logic             LastByte,
  output logic             Busy,
  output logic             Error
);

  localparam int CNT_W = ($clog2(SERVICE_BITS) > 3) ? $clog2(SERVICE_BITS) : 3;
  localparam logic [CNT_W-1:0] SVC_LAST  = CNT_W'(SERVICE_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);

  typedef enum logic [1:0] {IDLE, SERVICE, DATA} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bytecnt;
  logic [CNT_W-1:0] r_bitcnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_out_byte;
  logic             r_out_valid;
  logic             r_last;
  logic             r_err;

  logic [LEN_W-1:0] w_bytecnt_inc;
  logic             w_len_zero;
  logic             w_byte_done;
  logic             w_frame_done;

  assign w_bytecnt_inc = r_bytecnt + {{(LEN_W-1){1'b0}}, 1'b1};
  assign w_len_zero    = (Length == '0);
  assign w_byte_done   = InValid && (r_state == DATA) && (r_bitcnt == BYTE_LAST);
  assign w_frame_done  = w_byte_done && (w_bytecnt_inc == r_len);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Start overrides everything, including a frame in flight.
  always_comb begin
    w_next = r_state;
    if (Start) begin
      w_next = w_len_zero ? IDLE : SERVICE;
    end else begin
      case (r_state)
        SERVICE: if (InValid && (r_bitcnt == SVC_LAST)) w_next = DATA;
        DATA:    if (w_frame_done) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_len       <= '0;
      r_bytecnt   <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_out_byte  <= '0;
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_last      <= 1'b0;
      if (Start) begin
        r_len     <= Length;
        r_err     <= w_len_zero;
        r_bytecnt <= '0;
        r_bitcnt  <= '0;
        r_shift   <= '0;
      end else if (InValid) begin
        case (r_state)
          SERVICE: begin
            r_bitcnt <= (r_bitcnt == SVC_LAST) ? '0 : r_bitcnt + 1'b1;
            if (Input) r_err <= 1'b1;
          end
          DATA: begin
            if (r_bitcnt == BYTE_LAST) begin
              r_out_byte  <= {Input, r_shift[6:0]};
              r_out_valid <= 1'b1;
              r_last      <= w_frame_done;
              r_bytecnt   <= w_bytecnt_inc;
              r_bitcnt    <= '0;
            end else begin
              r_shift[r_bitcnt[2:0]] <= Input;
              r_bitcnt               <= r_bitcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign OutValid = r_out_valid;
  assign OutByte  = r_out_byte;
  assign LastByte = r_last;
  assign Busy     = (r_state != IDLE);
  assign Error    = r_err;

endmodule

// File: tb/tb_rx_deframer.sv
// tb/tb_rx_deframer.sv - randomized self-checking bench for rx_deframer.
// Expected bytes come from a frame-level model: whole data bytes sent, capped at Length.
module tb_rx_deframer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [11:0] Length;
  logic        InValid;
  logic        Input;
  logic        OutValid;
  logic [7:0]  OutByte;
  logic        LastByte;
  logic        Busy;
  logic        Error;

  rx_deframer #(.LEN_W(12), .SERVICE_BITS(16)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Length   (Length),
    .InValid  (InValid),
    .Input    (Input),
    .OutValid (OutValid),
    .OutByte  (OutByte),
    .LastByte (LastByte),
    .Busy     (Busy),
    .Error    (Error)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] exp_hold = 8'h00;
  logic [7:0] data [0:15];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b1) begin
      if (OutValid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_outvalid", 32'(OutValid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_byte", 32'(OutByte), 32'(mon_e[7:0]));
          check_eq("last_byte", 32'(LastByte), 32'(mon_e[8]));
          exp_hold = mon_e[7:0];
        end
      end else if (LastByte) begin
        check_eq("last_without_valid", 32'(LastByte), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int gap);
    repeat (gap) begin
      InValid = 1'b0;
      Input   = 1'($urandom);
      tick();
    end
    InValid = 1'b1;
    Input   = b;
    tick();
    InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      InValid = 1'b0;
      Input   = 1'($urandom);
      tick();
    end
  endtask

  // gap_mode: 0 = back-to-back bits, 1 = one idle cycle before every bit, 2 = random gaps
  task automatic run_frame(input int len, input int svc_pos, input int abort_bits, input int gap_mode);
    int   total;
    int   nbytes;
    int   gap;
    logic b;
    logic err;
    Start   = 1'b1;
    Length  = 12'(len);
    InValid = 1'($urandom);
    Input   = 1'($urandom);
    tick();
    Start   = 1'b0;
    InValid = 1'b0;
    check_eq("start_busy", 32'(Busy), 32'(len != 0));
    check_eq("start_error", 32'(Error), 32'(len == 0));
    if (len == 0) begin
      repeat (40) drive_bit(1'($urandom), 0);
      check_eq("len0_busy", 32'(Busy), 32'd0);
      check_eq("len0_error", 32'(Error), 32'd1);
      check_eq("len0_no_bytes", 32'(exp_q.size()), 32'd0);
      return;
    end
    total = 16 + 8 * len;
    if (abort_bits >= 0 && abort_bits < total) total = abort_bits;
    nbytes = (total > 16) ? (total - 16) / 8 : 0;
    for (int k = 0; k < nbytes; k++) exp_q.push_back({(k == len - 1), data[k]});
    err = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (i < 16) b = (i == svc_pos);
      else        b = data[(i - 16) / 8][(i - 16) % 8];
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      drive_bit(b, gap);
      if (i < 16) begin
        err = err | b;
        check_eq("svc_error", 32'(Error), 32'(err));
      end
    end
    if (total == 16 + 8 * len) begin
      check_eq("final_outvalid", 32'(OutValid), 32'd1);
      check_eq("busy_fall", 32'(Busy), 32'd0);
      check_eq("error_end", 32'(Error), 32'(err));
    end else begin
      check_eq("abort_busy", 32'(Busy), 32'd1);
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Start   = 1'b0;
    Length  = 12'd0;
    InValid = 1'b0;
    Input   = 1'b0;
    tick();
    tick();
    check_eq("rst_outvalid", 32'(OutValid), 32'd0);
    check_eq("rst_outbyte", 32'(OutByte), 32'd0);
    check_eq("rst_lastbyte", 32'(LastByte), 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_error", 32'(Error), 32'd0);
    Reset = 1'b1;
    idle(2);
    // bits presented without a Start are ignored
    repeat (10) drive_bit(1'b1, 0);
    check_eq("idle_busy", 32'(Busy), 32'd0);

    data[0] = 8'hA5;
    run_frame(1, -1, -1, 0);
    idle(2);
    check_eq("a5_drained", 32'(exp_q.size()), 32'd0);
    check_eq("a5_hold", 32'(OutByte), 32'(exp_hold));

    data[0] = 8'h01; data[1] = 8'h80; data[2] = 8'hFF;
    run_frame(3, -1, -1, 1);
    idle(2);
    check_eq("toggle_drained", 32'(exp_q.size()), 32'd0);

    data[0] = 8'h3C;
    run_frame(1, 5, -1, 0);
    idle(3);
    check_eq("err_sticky", 32'(Error), 32'd1);
    check_eq("err_drained", 32'(exp_q.size()), 32'd0);

    run_frame(0, -1, -1, 0);

    data[0] = 8'($urandom); data[1] = 8'($urandom);
    run_frame(2, -1, 20, 0);
    data[0] = 8'($urandom);
    run_frame(1, -1, -1, 0);
    idle(2);
    check_eq("abort_drained", 32'(exp_q.size()), 32'd0);

    for (int k = 0; k < 4; k++) data[k] = 8'($urandom);
    run_frame(4, -1, 16 + 8 + 3, 0);
    check_eq("pre_reset_drained", 32'(exp_q.size()), 32'd0);
    #2 Reset = 1'b0;
    #1;
    check_eq("async_outvalid", 32'(OutValid), 32'd0);
    check_eq("async_outbyte", 32'(OutByte), 32'd0);
    check_eq("async_lastbyte", 32'(LastByte), 32'd0);
    check_eq("async_busy", 32'(Busy), 32'd0);
    check_eq("async_error", 32'(Error), 32'd0);
    exp_q.delete();
    exp_hold = 8'h00;
    tick();
    Reset = 1'b1;
    repeat (40) drive_bit(1'($urandom), 0);
    check_eq("post_reset_busy", 32'(Busy), 32'd0);
    check_eq("post_reset_no_bytes", 32'(exp_q.size()), 32'd0);

    for (int f = 0; f < 30; f++) begin
      int len;
      int svc;
      int abrt;
      len  = int'($urandom_range(0, 5));
      svc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      abrt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16 + 8 * len - 1)) : -1;
      for (int k = 0; k < 16; k++) data[k] = 8'($urandom);
      run_frame(len, svc, abrt, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    check_eq("final_hold", 32'(OutByte), 32'(exp_hold));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
